// File: rtl/adc_capture_trigger.sv
// adc_capture_trigger
// Turns a rising edge on a debounced trigger level into a burst of ADC
// conversions: one convStart pulse per conversion, a programmable idle gap
// between conversions, a conversion counter and a burst-complete pulse.
//
// Optional feature: define ADC_TRIG_TIMEOUT_EN to arm a watchdog in
// WAIT_DONE that gives up after TIMEOUT_CYCLES clocks without adcDone and
// raises the sticky timeoutErr flag. Without the macro WAIT_DONE waits
// forever and timeoutErr is constant 0.
//
// Handshake with the ADC: convStart is a one-cycle request that is only
// issued in a cycle where adcBusy was sampled low; adcDone is a one-cycle
// completion strobe that is only honoured while a conversion is outstanding
// (WAIT_DONE) and is ignored everywhere else.
//
// o_dbg_state exposes the FSM state encoding for observation.

module adc_capture_trigger #(
    parameter int BURST_WIDTH    = 8,
    parameter int INTERVAL_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      trigIn,
    input  logic                      abort,
    input  logic [BURST_WIDTH-1:0]    burstLen,
    input  logic [INTERVAL_WIDTH-1:0] interval,
    input  logic                      adcBusy,
    input  logic                      adcDone,
    output logic                      convStart,
    output logic                      active,
    output logic [BURST_WIDTH-1:0]    sampleCount,
    output logic                      burstDone,
    output logic                      timeoutErr,
    output logic [1:0]                o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic                      r_trig_prev;
    logic                      r_trig_armed;
    logic                      w_start_cond;

    logic [BURST_WIDTH-1:0]    r_len;
    logic [BURST_WIDTH-1:0]    r_count;
    logic [BURST_WIDTH-1:0]    w_count_nxt;
    logic [BURST_WIDTH-1:0]    w_count_inc;

    logic [INTERVAL_WIDTH-1:0] r_interval;
    logic [INTERVAL_WIDTH-1:0] r_gap_cnt;
    logic [INTERVAL_WIDTH-1:0] w_gap_cnt_nxt;

    logic                      r_conv_start;
    logic                      w_conv_start_nxt;
    logic                      r_burst_done;
    logic                      w_burst_done_nxt;
    logic                      r_timeout_err;
    logic                      w_timeout_err_nxt;
    logic                      w_latch;
    logic                      w_timeout_hit;

    // A start needs a genuine low-to-high transition: the armed flag keeps a
    // trigger level that is already high when reset releases from counting
    // as an edge.
    assign w_start_cond = trigIn & ~r_trig_prev & r_trig_armed;
    assign w_count_inc  = r_count + 1'b1;

    // Trigger edge detector history and arming flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_prev  <= 1'b0;
            r_trig_armed <= 1'b0;
        end else begin
            r_trig_prev  <= trigIn;
            r_trig_armed <= r_trig_armed | ~trigIn;
        end
    end

`ifdef ADC_TRIG_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;

    // Clocks spent in WAIT_DONE; cleared whenever the FSM is elsewhere, so a
    // fresh conversion always starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_WAIT_DONE) begin
            r_tmo_cnt <= '0;
        end else if (!w_timeout_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout_hit = (r_state == S_WAIT_DONE) &&
                           (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Next-state, next-counter and strobe decode; abort wins over everything.
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_conv_start_nxt  = 1'b0;
        w_burst_done_nxt  = 1'b0;
        w_timeout_err_nxt = r_timeout_err;
        w_latch           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start_cond && (burstLen != '0)) begin
                    w_latch           = 1'b1;
                    w_count_nxt       = '0;
                    w_timeout_err_nxt = 1'b0;
                    w_state_nxt       = S_START;
                end
            end

            S_START: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!adcBusy) begin
                    w_conv_start_nxt = 1'b1;
                    w_state_nxt      = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (adcDone) begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == r_len) begin
                        w_burst_done_nxt = 1'b1;
                        w_state_nxt      = S_IDLE;
                    end else if (r_interval == '0) begin
                        w_state_nxt = S_START;
                    end else begin
                        // GAP lasts interval cycles, START adds the final one.
                        w_gap_cnt_nxt = r_interval - 1'b1;
                        w_state_nxt   = S_GAP;
                    end
                end else if (w_timeout_hit) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end
            end

            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_state_nxt = S_START;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, registered strobes, counters and per-burst settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_conv_start  <= 1'b0;
            r_burst_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_count       <= '0;
            r_gap_cnt     <= '0;
            r_len         <= '0;
            r_interval    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_conv_start  <= w_conv_start_nxt;
            r_burst_done  <= w_burst_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_count       <= w_count_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            if (w_latch) begin
                r_len      <= burstLen;
                r_interval <= interval;
            end
        end
    end

    assign convStart   = r_conv_start;
    assign burstDone   = r_burst_done;
    assign timeoutErr  = r_timeout_err;
    assign sampleCount = r_count;
    assign active      = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_adc_capture_trigger.sv
// Testbench for adc_capture_trigger.
// Each burst is planned up front from the behavioural rules: the edge of
// every convStart, every adcDone, the burstDone edge and the final count are
// computed with plain arithmetic, and the ADC responses (adcDone, adcBusy,
// abort, trigIn) are replayed from per-edge schedules. A monitor records the
// edges on which convStart/burstDone are seen and the scoreboard compares.

module tb_adc_capture_trigger;

    localparam int BW  = 8;
    localparam int IW  = 16;
    localparam int TMO = 20;
    localparam int W   = 32;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          trigIn, abort, adcBusy, adcDone;
    logic [BW-1:0] burstLen;
    logic [IW-1:0] interval;
    logic          convStart, active, burstDone, timeoutErr;
    logic [BW-1:0] sampleCount;
    logic [1:0]    dbg_state;

    adc_capture_trigger #(
        .BURST_WIDTH    (BW),
        .INTERVAL_WIDTH (IW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trigIn      (trigIn),
        .abort       (abort),
        .burstLen    (burstLen),
        .interval    (interval),
        .adcBusy     (adcBusy),
        .adcDone     (adcDone),
        .convStart   (convStart),
        .active      (active),
        .sampleCount (sampleCount),
        .burstDone   (burstDone),
        .timeoutErr  (timeoutErr),
        .o_dbg_state (dbg_state)
    );

    // Edge counter: after posedge number k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-edge stimulus schedules, keyed by the edge that samples them.
    bit done_set[int];
    bit busy_set[int];
    bit abort_set[int];
    bit trig_chg[int];

    // Scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_dn[$];
    logic [W-1:0] obs_conv[$];
    logic [W-1:0] obs_done[$];
    int exp_cnt, exp_bd, last_edge, t0;
    int n_checks = 0;
    int n_fail   = 0;

    // Monitor outputs and drive the inputs for the next rising edge.
    always @(negedge clk) begin
        if (convStart) obs_conv.push_back(cyc);
        if (burstDone) obs_done.push_back(cyc);
        adcDone = (done_set.exists(cyc + 1) != 0);
        adcBusy = (busy_set.exists(cyc + 1) != 0);
        abort   = (abort_set.exists(cyc + 1) != 0);
        if (trig_chg.exists(cyc + 1) != 0) trigIn = trig_chg[cyc + 1];
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Return just after the negedge that follows rising edge e.
    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk);
        #1;
    endtask

    task automatic clear_all();
        done_set.delete();
        busy_set.delete();
        abort_set.delete();
        trig_chg.delete();
        exp_q.delete();
        exp_dn.delete();
        obs_conv.delete();
        obs_done.delete();
    endtask

    // Build the schedule and expectations for one burst.
    task automatic plan_burst(input int len, input int gap, input int abort_k,
                              input bit retog, input int b0, input int lat_fix);
        int c, d, lat, b;
        clear_all();
        burstLen = BW'(len);
        interval = IW'(gap);
        t0 = cyc + 2;
        trig_chg[t0] = 1'b1;
        for (int k = 1; k <= b0; k++) busy_set[t0 + k] = 1'b1;
        c = t0 + 1 + b0;
        exp_cnt   = 0;
        exp_bd    = -1;
        last_edge = c;
        for (int i = 0; i < len; i++) begin
            lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
            exp_q.push_back(c);
            d = c + lat;
            exp_dn.push_back(d);
            done_set[d] = 1'b1;
            last_edge = d;
            if (i == abort_k) begin
                abort_set[d] = 1'b1;
                break;
            end
            exp_cnt = i + 1;
            if (i == len - 1) begin
                exp_bd = d;
            end else begin
                b = $urandom_range(0, 3);
                for (int k = 1; k <= b; k++) busy_set[d + k] = 1'b1;
                c = (gap > b) ? d + gap + 1 : d + b + 1;
            end
        end
        if (retog && exp_q.size() >= 2) begin
            trig_chg[exp_q[0] + 1] = 1'b0;
            trig_chg[exp_q[0] + 2] = 1'b1;
        end
        trig_chg[last_edge + 1] = 1'b0;
    endtask

    task automatic run_burst(input int len, input int gap, input int abort_k,
                             input bit retog, input int b0, input int lat_fix);
        plan_burst(len, gap, abort_k, retog, b0, lat_fix);
        wait_edge(t0 - 1);
        check_val("idle_before_trig", active, 0);
        wait_edge(t0);
        check_val("active_after_trig", active, 1);
        check_val("terr_clear_on_start", timeoutErr, 0);
        check_val("count_clear_on_start", sampleCount, 0);
        wait_edge(exp_q[0]);
        burstLen = BW'($urandom);
        interval = IW'($urandom);
        wait_edge(last_edge + 3);
        check_val("active_after_burst", active, 0);
        check_val("final_count", sampleCount, exp_cnt);
        check_val("conv_pulses", obs_conv.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_conv.size(); i++)
            check_val($sformatf("conv%0d_edge", i), obs_conv[i], exp_q[i]);
        check_val("done_pulses", obs_done.size(), (exp_bd >= 0) ? 1 : 0);
        if (exp_bd >= 0 && obs_done.size() > 0)
            check_val("done_edge", obs_done[0], exp_bd);
        check_val("terr_after_burst", timeoutErr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, len, gap, ak;
        rst_n = 1'b0;
        trigIn = 1'b0; abort = 1'b0; adcBusy = 1'b0; adcDone = 1'b0;
        burstLen = '0; interval = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_convStart", convStart, 0);
        check_val("rst_active", active, 0);
        check_val("rst_sampleCount", sampleCount, 0);
        check_val("rst_burstDone", burstDone, 0);
        check_val("rst_timeoutErr", timeoutErr, 0);
        check_val("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        wait_edge(cyc + 3);

        // Four conversions back to back, done three clocks after each start.
        run_burst(4, 0, -1, 1'b0, 0, 3);
        // Gap of five with a trigger retoggle mid-burst.
        run_burst(3, 5, -1, 1'b1, 0, 0);
        // ADC busy for ten clocks when the burst begins.
        run_burst(2, 0, -1, 1'b0, 10, 0);
        // Abort together with the second adcDone.
        run_burst(8, 1, 1, 1'b0, 0, 0);

        // Zero-length burst request is ignored.
        clear_all();
        burstLen = '0;
        interval = '0;
        t0 = cyc + 2;
        trig_chg[t0] = 1'b1;
        trig_chg[t0 + 3] = 1'b0;
        wait_edge(t0);
        check_val("len0_active", active, 0);
        wait_edge(t0 + 5);
        check_val("len0_active_late", active, 0);
        check_val("len0_conv_pulses", obs_conv.size(), 0);

        // Withheld adcDone.
        clear_all();
        burstLen = BW'(2);
        interval = '0;
        t0 = cyc + 2;
        trig_chg[t0] = 1'b1;
        trig_chg[t0 + 3] = 1'b0;
        wait_edge(t0 + 1);
        check_val("tmo_conv_issued", obs_conv.size(), 1);
`ifdef ADC_TRIG_TIMEOUT_EN
        wait_edge(t0 + 1 + TMO - 1);
        check_val("tmo_not_yet", timeoutErr, 0);
        check_val("tmo_still_active", active, 1);
        wait_edge(t0 + 1 + TMO);
        check_val("tmo_flag_set", timeoutErr, 1);
        check_val("tmo_idle", active, 0);
        check_val("tmo_no_burstDone", obs_done.size(), 0);
        wait_edge(cyc + 2);
        check_val("tmo_flag_sticky", timeoutErr, 1);
`else
        wait_edge(t0 + 1 + TMO + 10);
        check_val("nowait_still_active", active, 1);
        check_val("nowait_terr_zero", timeoutErr, 0);
        e = cyc + 2;
        abort_set[e] = 1'b1;
        wait_edge(e);
        check_val("nowait_abort_idle", active, 0);
`endif
        wait_edge(cyc + 2);
        run_burst(2, 0, -1, 1'b0, 0, 0);

        // Reset in the middle of a gap, with trigIn held high across it.
        plan_burst(3, 5, -1, 1'b0, 0, 2);
        wait_edge(exp_dn[0] + 2);
        check_val("pre_rst_active", active, 1);
        check_val("pre_rst_count", sampleCount, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_convStart", convStart, 0);
        check_val("midrst_active", active, 0);
        check_val("midrst_sampleCount", sampleCount, 0);
        check_val("midrst_burstDone", burstDone, 0);
        check_val("midrst_timeoutErr", timeoutErr, 0);
        clear_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        wait_edge(cyc + 6);
        check_val("rel_high_trig_active", active, 0);
        check_val("rel_high_trig_conv", obs_conv.size(), 0);
        trig_chg[cyc + 2] = 1'b0;
        wait_edge(cyc + 3);

        // Largest burst length completes without the counter wrapping.
        run_burst(255, 0, -1, 1'b0, 0, 1);

        // Randomized bursts.
        for (int n = 0; n < 12; n++) begin
            len = $urandom_range(1, 6);
            gap = $urandom_range(0, 4);
            ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_burst(len, gap, ak, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
